uart_tx_link: RTL and testbench

//  Sending end of the command-line character link. Pulls response characters from the

---
 rtl/uart_tx_link.sv | 218 +++++++++++++++++++++
 tb/tb_uart_tx_link.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_link.sv
// Sending end of the command-line character link: requests characters from the cmdline
// block, buffers them in a small FIFO and serializes them as 8N1 UART frames.
module uart_tx_link #(
  parameter int unsigned CLK_DIV       = 104,
  parameter int unsigned FIFO_AW       = 2,
  parameter int unsigned STROBE_CYCLES = 512,
  parameter int unsigned WAIT_TIMEOUT  = 4096
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_avail,
  output logic       tx_strobe,
  output logic       uart_txd,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned Depth   = 2 ** FIFO_AW;
  localparam int unsigned TxCntW  = $clog2(CLK_DIV);
  localparam int unsigned ReqMax  = (STROBE_CYCLES > WAIT_TIMEOUT) ? STROBE_CYCLES : WAIT_TIMEOUT;
  localparam int unsigned ReqCntW = $clog2(ReqMax);

  typedef enum logic [1:0] {RIdle, RStrobe, RWait, RGap} req_state_e;
  typedef enum logic [1:0] {TIdle, TStart, TData, TStop} tx_state_e;

  logic               avail_q;
  logic [7:0]         mem_q [Depth];
  logic [7:0]         mem_d [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  req_state_e         req_state_q, req_state_d;
  logic [ReqCntW-1:0] req_cnt_q, req_cnt_d;
  logic               got_q, got_d;
  logic               strobe_q, strobe_d;

  tx_state_e          tx_state_q, tx_state_d;
  logic [TxCntW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;
  logic               busy_q, busy_d;

  logic avail_rise, full, empty, wr_en, pop;

  assign avail_rise = tx_avail & ~avail_q;
  assign full       = (count_q == (FIFO_AW + 1)'(Depth));
  assign empty      = (count_q == '0);
  assign wr_en      = avail_rise & ~full;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (avail_rise & full);
    if (wr_en) begin
      mem_d[wr_ptr_q] = tx_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A response seen while the strobe is high is remembered so the strobe keeps its full
  // width, then the FSM skips the wait phase and goes straight to the gap.
  always_comb begin
    req_state_d = req_state_q;
    req_cnt_d   = req_cnt_q;
    got_d       = got_q;
    unique case (req_state_q)
      RIdle: begin
        if (!full) begin
          req_state_d = RStrobe;
          req_cnt_d   = ReqCntW'(STROBE_CYCLES - 1);
          got_d       = 1'b0;
        end
      end
      RStrobe: begin
        if (avail_rise) got_d = 1'b1;
        if (req_cnt_q == '0) begin
          if (got_q || avail_rise) begin
            req_state_d = RGap;
            req_cnt_d   = ReqCntW'(STROBE_CYCLES - 1);
          end else begin
            req_state_d = RWait;
            req_cnt_d   = ReqCntW'(WAIT_TIMEOUT - 1);
          end
        end else begin
          req_cnt_d = req_cnt_q - 1'b1;
        end
      end
      RWait: begin
        if (avail_rise || req_cnt_q == '0) begin
          req_state_d = RGap;
          req_cnt_d   = ReqCntW'(STROBE_CYCLES - 1);
        end else begin
          req_cnt_d = req_cnt_q - 1'b1;
        end
      end
      RGap: begin
        if (req_cnt_q == '0) begin
          req_state_d = RIdle;
        end else begin
          req_cnt_d = req_cnt_q - 1'b1;
        end
      end
      default: req_state_d = RIdle;
    endcase
    strobe_d = (req_state_d == RStrobe);
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    unique case (tx_state_q)
      TIdle: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_d    = mem_q[rd_ptr_q];
          tx_state_d = TStart;
          tx_cnt_d   = TxCntW'(CLK_DIV - 1);
        end
      end
      TStart: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TData;
          bit_idx_d  = 3'd0;
          tx_cnt_d   = TxCntW'(CLK_DIV - 1);
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      TData: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = TxCntW'(CLK_DIV - 1);
          if (bit_idx_q == 3'd7) begin
            tx_state_d = TStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      TStop: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TIdle;
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      default: tx_state_d = TIdle;
    endcase
    // Line level is derived from the next state so txd comes straight from a flop.
    unique case (tx_state_d)
      TStart:  txd_d = 1'b0;
      TData:   txd_d = shift_d[bit_idx_d];
      default: txd_d = 1'b1;
    endcase
    busy_d = (count_d != '0) | (tx_state_d != TIdle);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      avail_q     <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      req_state_q <= RIdle;
      req_cnt_q   <= '0;
      got_q       <= 1'b0;
      strobe_q    <= 1'b0;
      tx_state_q  <= TIdle;
      tx_cnt_q    <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      avail_q     <= tx_avail;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      req_state_q <= req_state_d;
      req_cnt_q   <= req_cnt_d;
      got_q       <= got_d;
      strobe_q    <= strobe_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_strobe = strobe_q;
  assign uart_txd  = txd_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_link.sv
// Bench for uart_tx_link: queue/timestamp reference model of FIFO and frames, a UART
// receiver on txd, and direct measurements of the request strobe timing.
module tb_uart_tx_link;

  localparam int unsigned D     = 104;
  localparam int unsigned DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_avail = 1'b0;
  logic       tx_strobe, uart_txd, busy, overflow;

  uart_tx_link #(
    .CLK_DIV      (D),
    .FIFO_AW      (2),
    .STROBE_CYCLES(512),
    .WAIT_TIMEOUT (4096)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_avail (tx_avail),
    .tx_strobe(tx_strobe),
    .uart_txd (uart_txd),
    .busy     (busy),
    .overflow (overflow)
  );

  initial forever #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, transmitter as "frame occupies 10*D clocks from pop".
  longint     cyc = 0;
  logic [7:0] m_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  longint     m_pop = 0;
  longint     m_end = -1;
  logic       m_valid = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_prev = 1'b0;

  initial begin
    int  sz;
    logic rise;
    forever begin
      @(posedge clock);
      cyc++;
      if (!reset) begin
        m_q.delete();
        m_end   = -1;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_prev  = 1'b0;
      end else begin
        sz     = m_q.size();
        rise   = tx_avail && !m_prev;
        m_prev = tx_avail;
        if (sz != 0 && cyc > m_end) begin
          m_byte  = m_q.pop_front();
          m_pop   = cyc;
          m_end   = cyc + 10 * longint'(D);
          m_valid = 1'b1;
          sent_q.push_back(m_byte);
        end
        if (rise) begin
          if (sz == DEPTH) m_ovf = 1'b1;
          else m_q.push_back(tx_data);
        end
      end
    end
  end

  function automatic logic exp_txd();
    longint dt;
    int     k;
    dt = cyc - m_pop;
    if (m_valid && dt < 10 * longint'(D)) begin
      k = int'(dt / longint'(D));
      if (k == 0) return 1'b0;
      if (k <= 8) return m_byte[k-1];
    end
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      if (cyc > 0) begin
        chk("txd", uart_txd, exp_txd());
        chk("busy", busy, (m_q.size() != 0) || (m_valid && cyc < m_end));
        chk("ovf", overflow, m_ovf);
      end
    end
  end

  // UART receiver sampling mid-bit; frames cut by reset are discarded.
  initial begin
    logic       last = 1'b1;
    logic       ok;
    logic [7:0] b;
    forever begin
      @(negedge clock);
      if (reset && last === 1'b1 && uart_txd === 1'b0) begin
        ok = 1'b1;
        repeat (D / 2) begin @(negedge clock); if (!reset) ok = 1'b0; end
        if (uart_txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (D) begin @(negedge clock); if (!reset) ok = 1'b0; end
          b[i] = uart_txd;
        end
        repeat (D) begin @(negedge clock); if (!reset) ok = 1'b0; end
        if (ok) begin
          chk("stop_bit", uart_txd, 1'b1);
          rx_q.push_back(b);
        end
      end
      last = uart_txd;
    end
  end

  task automatic pulse(input logic [7:0] b, input int hi, input int lo);
    tx_data  = b;
    tx_avail = 1'b1;
    repeat (hi) @(negedge clock);
    tx_avail = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  task automatic wait_lvl(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (tx_strobe !== lvl && n < budget) begin @(negedge clock); n++; end
    chk(tag, tx_strobe, lvl);
  endtask

  task automatic measure(input logic lvl, input int budget, output int n);
    n = 0;
    while (tx_strobe === lvl && n < budget) begin @(negedge clock); n++; end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    repeat (2) @(negedge clock);
    while (busy !== 1'b0 && n < budget) begin @(negedge clock); n++; end
    chk(tag, busy, 1'b0);
    repeat (60) @(negedge clock);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) chk(tag, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
    sent_q.delete();
  endtask

  initial begin
    int         nh, nl, n;
    logic [7:0] b [5];
    logic [7:0] r;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_strobe", tx_strobe, 1'b0);
    chk("rst_txd", uart_txd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    reset = 1'b1;

    // Consumer answers three strobes with 'O', 'K', LF
    b[0] = 8'h4F; b[1] = 8'h4B; b[2] = 8'h0A;
    for (int i = 0; i < 3; i++) begin
      wait_lvl(1'b0, 6000, "t1_low");
      wait_lvl(1'b1, 6000, "t1_rise");
      repeat (20) @(negedge clock);
      pulse(b[i], 256, 0);
    end
    wait_idle(6000, "t1_idle");
    exp_q = '{8'h4F, 8'h4B, 8'h0A};
    check_rx("t1_rx");

    // Strobe width with a response at +300, then the low gap before the next request
    wait_lvl(1'b0, 6000, "t2_low");
    wait_lvl(1'b1, 6000, "t2_rise");
    fork
      begin repeat (300) @(negedge clock); pulse(8'h55, 256, 0); end
      begin measure(1'b1, 1000, nh); measure(1'b0, 6000, nl); end
    join
    chk("t2_high", nh, 512);
    chk("t2_gap_min", nl >= 512, 1'b1);
    chk("t2_no_timeout", nl <= 520, 1'b1);

    // No response: re-request after timeout plus gap
    wait_lvl(1'b0, 6000, "t3_low");
    wait_lvl(1'b1, 6000, "t3_rise");
    measure(1'b1, 1000, nh);
    chk("t3_high", nh, 512);
    measure(1'b0, 6000, nl);
    chk("t3_rerise_min", nl >= 4608, 1'b1);
    chk("t3_rerise_max", nl <= 4610, 1'b1);
    wait_idle(3000, "t3_idle");
    exp_q = '{8'h55};
    check_rx("t3_rx");

    // Capture on the same clock as the idle pop with one entry queued
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    pulse(b[0], 4, 20);
    pulse(b[1], 4, 20);
    n = 0;
    while (cyc != m_end && n < 3000) begin @(negedge clock); n++; end
    chk("t5_sync", cyc == m_end, 1'b1);
    pulse(b[2], 4, 20);
    chk("t5_busy", busy, 1'b1);
    wait_idle(6000, "t5_idle");
    exp_q = '{b[0], b[1], b[2]};
    check_rx("t5_rx");

    // Overflow: one byte in flight, four queued, fifth dropped
    r = 8'($urandom);
    pulse(r, 4, 4);
    for (int i = 0; i < 5; i++) begin
      b[i] = 8'($urandom);
      pulse(b[i], 4, 4);
    end
    repeat (2) @(negedge clock);
    chk("t4_ovf", overflow, 1'b1);
    wait_idle(8000, "t4_idle");
    chk("t4_ovf_sticky", overflow, 1'b1);
    exp_q = '{r, b[0], b[1], b[2], b[3]};
    check_rx("t4_rx");

    // Reset in the middle of data bit 3
    r = 8'($urandom);
    pulse(r, 4, 4);
    n = 0;
    while (!(m_valid && (cyc - m_pop) == 4 * longint'(D) + D / 2) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk("t6_sync", n < 3000, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    chk("t6_txd", uart_txd, 1'b1);
    chk("t6_busy", busy, 1'b0);
    chk("t6_strobe", tx_strobe, 1'b0);
    chk("t6_ovf", overflow, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (1200) @(negedge clock);
    rx_q.delete();
    sent_q.delete();
    r = 8'($urandom);
    pulse(r, 4, 4);
    wait_idle(3000, "t6_idle");
    exp_q = '{r};
    check_rx("t6_rx");

    // Random bytes with random spacing against the model's transmit order
    for (int i = 0; i < 8; i++) pulse(8'($urandom), 4, int'($urandom_range(30, 1400)));
    wait_idle(20000, "t7_idle");
    exp_q = sent_q;
    chk("t7_nonempty", exp_q.size() != 0, 1'b1);
    check_rx("t7_rx");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
